bz_melody_seq: RTL and testbench

BZ_MELODY_SEQ -- requirements
Module: bz_melody_seq

---
 rtl/bz_melody_seq.sv | 178 +++++++++++++++++
 tb/tb_bz_melody_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bz_melody_seq.sv
// Melody sequencer: plays a fixed 7-note ROM tune as a square wave on BZ,
// with per-note duration, inter-note gap, optional looping and abort.
module bz_melody_seq #(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned TICK_DIV = 600000,
    parameter int unsigned GAP_CYC  = 60000
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOOP,
    output logic       BZ,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] NOTE_IDX
);

    localparam int unsigned CNT_W  = $clog2(15 * TICK_DIV + GAP_CYC + 1);
    localparam int unsigned TONE_W = $clog2(CLK_HZ / 524 + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // {code[2:0], dur[3:0]}; dur == 0 is the terminator
    function automatic logic [6:0] rom_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return {3'd1, 4'd4};
            3'd1:    return {3'd3, 4'd4};
            3'd2:    return {3'd5, 4'd4};
            3'd3:    return {3'd6, 4'd2};
            3'd4:    return {3'd5, 4'd2};
            3'd5:    return {3'd3, 4'd4};
            3'd6:    return {3'd1, 4'd8};
            default: return {3'd0, 4'd0};
        endcase
    endfunction

    // Last tone-counter value before BZ toggles: HALF(code) - 1
    function automatic logic [TONE_W-1:0] half_last(input logic [2:0] code);
        int unsigned freq;
        case (code)
            3'd1:    freq = 262;
            3'd2:    freq = 294;
            3'd3:    freq = 330;
            3'd4:    freq = 349;
            3'd5:    freq = 392;
            3'd6:    freq = 440;
            3'd7:    freq = 494;
            default: freq = 0;
        endcase
        if (freq == 0) return '0;
        return TONE_W'(CLK_HZ / (2 * freq) - 1);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lim_q, lim_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [TONE_W-1:0] half_q, half_d;
    logic              bz_q, bz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [6:0]        entry;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            tone_q  <= '0;
            half_q  <= '0;
            bz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            tone_q  <= tone_d;
            half_q  <= half_d;
            bz_q    <= bz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        tone_d  = tone_q;
        half_d  = half_q;
        bz_d    = bz_q;
        done_d  = 1'b0;
        entry   = rom_entry(idx_q);

        case (state_q)
            S_IDLE: begin
                bz_d = 1'b0;
                if (START && !STOP) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                code_d = entry[6:4];
                half_d = half_last(entry[6:4]);
                lim_d  = CNT_W'(entry[3:0]) * CNT_W'(TICK_DIV) - CNT_W'(1);
                cnt_d  = '0;
                tone_d = '0;
                bz_d   = 1'b0;
                if (entry[3:0] != 4'd0) begin
                    state_d = S_PLAY;
                end else begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = LOOP ? S_LOAD : S_IDLE;
                end
            end
            S_PLAY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (code_q != 3'd0) begin
                    if (tone_q == half_q) begin
                        tone_d = '0;
                        bz_d   = ~bz_q;
                    end else begin
                        tone_d = tone_q + TONE_W'(1);
                    end
                end
                if (cnt_q == lim_q) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    tone_d  = '0;
                    bz_d    = 1'b0;
                end
            end
            S_GAP: begin
                bz_d  = 1'b0;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a pending terminator DONE
        if (STOP && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            tone_d  = '0;
            bz_d    = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign BZ       = bz_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign NOTE_IDX = idx_q;

endmodule

// File: tb/tb_bz_melody_seq.sv
// Directed bench for bz_melody_seq: idle vector table, then tone, loop,
// full-pass timing, abort and asynchronous reset sequences.
module tb_bz_melody_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, loop;
    logic       bz, busy, done;
    logic [2:0] idx;

    int n_vec    = 0;
    int n_err    = 0;
    int t        = 0;
    int done_cnt = 0;
    int busy_low = 0;
    int d0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       loop;
        logic       busy;
        logic       bz;
        logic       done;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[7];

    bz_melody_seq #(
        .CLK_HZ  (52400),
        .TICK_DIV(1000),
        .GAP_CYC (10)
    ) dut (
        .CLK_IN  (clk),
        .RST_N   (rst_n),
        .START   (start),
        .STOP    (stop),
        .LOOP    (loop),
        .BZ      (bz),
        .BUSY    (busy),
        .DONE    (done),
        .NOTE_IDX(idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!busy) busy_low++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Advance to edge number 'target' counted from the START-sampling edge
    task automatic adv_to(input int target);
        while (t < target) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    task automatic start_pass();
        start = 1'b1;
        @(posedge clk);
        t = 0;
        #1;
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 0, 0, 0, 3'd0};  // START+STOP in IDLE: stay idle
        vecs[1] = '{0, 0, 0, 0, 0, 0, 3'd0};
        vecs[2] = '{1, 0, 0, 1, 0, 0, 3'd0};  // LOAD step 0
        vecs[3] = '{0, 0, 0, 1, 0, 0, 3'd0};  // first PLAY cycle
        vecs[4] = '{1, 0, 0, 1, 0, 0, 3'd0};  // START while busy ignored
        vecs[5] = '{0, 1, 0, 0, 0, 0, 3'd0};  // STOP aborts
        vecs[6] = '{0, 0, 0, 0, 0, 0, 3'd0};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        loop  = 1'b0;
        #12;
        chk("rst.bz", bz, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.idx", idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            loop  = vecs[i].loop;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d.bz", i), bz, vecs[i].bz);
            chk($sformatf("v%0d.done", i), done, vecs[i].done);
            chk($sformatf("v%0d.idx", i), idx, vecs[i].idx);
        end
        start = 1'b0;
        stop  = 1'b0;

        // Looping pass, then a second pass with LOOP dropped
        loop     = 1'b1;
        done_cnt = 0;
        start_pass();
        busy_low = 0;
        chk("tone.busy0", busy, 1);
        adv_to(100);   chk("tone.bz100", bz, 0);
        adv_to(101);   chk("tone.bz101", bz, 1);
        adv_to(200);   chk("tone.bz200", bz, 1);
        adv_to(201);   chk("tone.bz201", bz, 0);
        adv_to(5000);
        start = 1'b1;
        adv_to(5001);
        start = 1'b0;
        chk("ign.idx", idx, 1);
        adv_to(12033); chk("s3.idx", idx, 3);
        adv_to(12092); chk("s3.bz12092", bz, 0);
        adv_to(12093); chk("s3.bz12093", bz, 1);
        adv_to(12151); chk("s3.bz12151", bz, 1);
        adv_to(12152); chk("s3.bz12152", bz, 0);
        adv_to(20066); chk("loop.idx6", idx, 6);
        adv_to(28077); chk("loop.idx7", idx, 7);
        chk("loop.nodone", done, 0);
        adv_to(28078);
        chk("loop.done", done, 1);
        chk("loop.busy", busy, 1);
        chk("loop.idx0", idx, 0);
        loop = 1'b0;
        adv_to(28079); chk("loop.doneoff", done, 0);
        adv_to(56155);
        chk("pass.predone", done, 0);
        chk("pass.busylow", busy_low, 0);
        adv_to(56156);
        chk("pass.done", done, 1);
        chk("pass.busy", busy, 0);
        adv_to(56158);
        chk("pass.donecnt", done_cnt, 2);

        // Abort during step 2, then replay from step 0
        d0 = done_cnt;
        start_pass();
        adv_to(8500);
        chk("abort.idx2", idx, 2);
        chk("abort.busy", busy, 1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        chk("abort.busy0", busy, 0);
        chk("abort.bz", bz, 0);
        chk("abort.idx", idx, 0);
        chk("abort.done", done, 0);
        @(posedge clk);
        #1;
        chk("abort.stay", busy, 0);
        chk("abort.donecnt", done_cnt, d0);
        start_pass();
        chk("replay.busy", busy, 1);
        adv_to(1);   chk("replay.idx", idx, 0);
        adv_to(101); chk("replay.bz", bz, 1);

        // Asynchronous reset mid-note, checked before any clock edge
        adv_to(150);
        chk("arst.pre", bz, 1);
        rst_n = 1'b0;
        #2;
        chk("arst.bz", bz, 0);
        chk("arst.busy", busy, 0);
        chk("arst.done", done, 0);
        chk("arst.idx", idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
